// File: rtl/updown_sweep_ctrl_if.sv
// Control/observe bundle between the sweep sequencer and whoever owns the
// up/down counter; master drives commands and the counter value, slave is the sequencer.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   count_in;
  logic               up;
  logic               down;
  logic               ctr_clear_b;
  logic               busy;
  logic               dir;
  logic               done;
  logic               err;
  logic [SWEEP_W-1:0] sweeps;

  modport master (
    output start, stop, continuous, lo, hi, count_in,
    input  up, down, ctr_clear_b, busy, dir, done, err, sweeps
  );

  modport slave (
    input  start, stop, continuous, lo, hi, count_in,
    output up, down, ctr_clear_b, busy, dir, done, err, sweeps
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a WIDTH-bit up/down counter: clear, ramp to lo, then bounce
// between lo and hi once or until stopped, counting completed sweeps.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
) (
  input logic                clk,
  input logic                clear_b,
  updown_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    SEEK = 3'd2,
    UP   = 3'd3,
    DOWN = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [SWEEP_W-1:0] SWEEP_ONE = {{(SWEEP_W-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic               cont_q;
  logic [SWEEP_W-1:0] sweeps_q;
  logic               ctr_clear_b_q, busy_q, dir_q, done_q, err_q;
  logic               up_c, down_c, sweep_done;
  logic               accept, reject;

  // A start is only looked at in IDLE, and stop always overrides it.
  assign accept = (state == IDLE) && bus.start && !bus.stop && (bus.lo <  bus.hi);
  assign reject = (state == IDLE) && bus.start && !bus.stop && (bus.lo >= bus.hi);

  always_comb begin
    state_nxt  = state;
    up_c       = 1'b0;
    down_c     = 1'b0;
    sweep_done = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = CLR;
      CLR:  state_nxt = SEEK;
      SEEK: begin
        if (bus.count_in < lo_q) begin
          up_c = 1'b1;
        end else if (bus.count_in == lo_q) begin
          up_c      = 1'b1;
          state_nxt = UP;
        end else begin
          down_c = 1'b1;
        end
      end
      UP: begin
        if (bus.count_in != hi_q) begin
          up_c = 1'b1;
        end else begin
          down_c    = 1'b1;
          state_nxt = DOWN;
        end
      end
      DOWN: begin
        if (bus.count_in != lo_q) begin
          down_c = 1'b1;
        end else begin
          sweep_done = 1'b1;
          if (cont_q) begin
            up_c      = 1'b1;
            state_nxt = UP;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort freezes the counter in the same cycle; a sweep landing on lo
    // in that cycle is not credited.
    if (bus.stop && (state != IDLE)) begin
      up_c       = 1'b0;
      down_c     = 1'b0;
      sweep_done = 1'b0;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state         <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      cont_q        <= 1'b0;
      sweeps_q      <= '0;
      ctr_clear_b_q <= 1'b0;
      busy_q        <= 1'b0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Outputs are registered from the next state so they line up with it.
      ctr_clear_b_q <= (state_nxt != CLR);
      busy_q        <= (state_nxt != IDLE);
      dir_q         <= (state_nxt == SEEK) || (state_nxt == UP);
      done_q        <= (state_nxt == DONE);
      err_q         <= reject;
      if (accept) begin
        lo_q     <= bus.lo;
        hi_q     <= bus.hi;
        cont_q   <= bus.continuous;
        sweeps_q <= '0;
      end else if (sweep_done) begin
        sweeps_q <= sweeps_q + SWEEP_ONE;
      end
    end
  end

  assign bus.up          = up_c;
  assign bus.down        = down_c;
  assign bus.ctr_clear_b = ctr_clear_b_q;
  assign bus.busy        = busy_q;
  assign bus.dir         = dir_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.sweeps      = sweeps_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a plain up/down counter closes the loop and a
// sweep-trace model predicts every cycle's outputs.
module tb_updown_sweep_ctrl;

  logic clk = 1'b0;
  logic clear_b = 1'b0;
  always #5 clk = ~clk;

  updown_sweep_ctrl_if #(.WIDTH(4), .SWEEP_W(8)) bus ();
  updown_sweep_ctrl_if #(.WIDTH(4), .SWEEP_W(2)) bus2 ();

  updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut  (.clk(clk), .clear_b(clear_b), .bus(bus.slave));
  updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(2)) dut2 (.clk(clk), .clear_b(clear_b), .bus(bus2.slave));

  // Counters under control, with asynchronous clear.
  logic [3:0] cnt, cnt2;
  always_ff @(posedge clk or negedge bus.ctr_clear_b)
    if (!bus.ctr_clear_b) cnt <= 4'd0;
    else if (bus.up)      cnt <= cnt + 4'd1;
    else if (bus.down)    cnt <= cnt - 4'd1;
  always_ff @(posedge clk or negedge bus2.ctr_clear_b)
    if (!bus2.ctr_clear_b) cnt2 <= 4'd0;
    else if (bus2.up)      cnt2 <= cnt2 + 4'd1;
    else if (bus2.down)    cnt2 <= cnt2 - 4'd1;
  assign bus.count_in  = cnt;
  assign bus2.count_in = cnt2;

  typedef struct packed {
    logic [3:0] cnt;
    logic       up, down, ccb, busy, dir, done, err;
    logic [7:0] sw;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t idle_exp;

  function automatic obs_t mk(input int c, input bit u, input bit d, input bit ccb,
                              input bit b, input bit dr, input bit dn, input bit e, input int sw);
    obs_t o;
    o.cnt = 4'(c); o.up = u; o.down = d; o.ccb = ccb; o.busy = b;
    o.dir = dr; o.done = dn; o.err = e; o.sw = 8'(sw);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cnt = cnt; o.up = bus.up; o.down = bus.down; o.ccb = bus.ctr_clear_b;
    o.busy = bus.busy; o.dir = bus.dir; o.done = bus.done; o.err = bus.err;
    o.sw = bus.sweeps;
    return o;
  endfunction

  // Expected per-cycle trace starting at the CLR cycle: clear, climb 0..lo,
  // then nsw round trips lo+1..hi..lo, then DONE/IDLE for a single sweep.
  task automatic gen_sweep(input int lo, input int hi, input bit cont, input int nsw);
    int sw = 0;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int c = 0; c <= lo; c++) exp_q.push_back(mk(c, 1, 0, 1, 1, 1, 0, 0, sw));
    for (int s = 0; s < nsw; s++) begin
      for (int c = lo + 1; c <= hi; c++)
        exp_q.push_back(mk(c, c != hi, c == hi, 1, 1, 1, 0, 0, sw));
      for (int c = hi - 1; c >= lo; c--)
        exp_q.push_back(mk(c, (c == lo) && cont, c != lo, 1, 1, 0, 0, 0, sw));
      sw++;
    end
    if (!cont) begin
      exp_q.push_back(mk(lo, 0, 0, 1, 1, 0, 1, 0, sw));
      exp_q.push_back(mk(lo, 0, 0, 1, 0, 0, 0, 0, sw));
    end
  endtask

  task automatic start_op(input int lo, input int hi, input bit cont);
    @(posedge clk); #1;
    bus.lo = 4'(lo); bus.hi = 4'(hi); bus.continuous = cont; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.lo = 4'($urandom); bus.hi = 4'($urandom); bus.continuous = 1'($urandom);
  endtask

  task automatic scramble(input bit busy_now);
    bus.start      = busy_now ? 1'($urandom) : 1'b0;
    bus.lo         = 4'($urandom);
    bus.hi         = 4'($urandom);
    bus.continuous = 1'($urandom);
  endtask

  task automatic test_reset();
    obs_t o, e;
    clear_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = observe(); e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", o, e); end
    checks++;
    if ({bus2.busy, bus2.ctr_clear_b, bus2.sweeps} !== 4'b0000) begin
      errors++; $display("FAIL reset_dut2: got %b expected 0000", {bus2.busy, bus2.ctr_clear_b, bus2.sweeps});
    end
    clear_b = 1'b1;
    e = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_release[%0d]: got %h expected %h", i, o, e); end
    end
    idle_exp = e;
  endtask

  task automatic test_single_sweep();
    obs_t o;
    gen_sweep(2, 5, 1'b0, 1);
    start_op(2, 5, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL single[%0d]: got %h expected %h", i, o, exp_q[i]); end
      scramble(exp_q[i].busy);
    end
    idle_exp = exp_q[exp_q.size()-1];
  endtask

  task automatic test_bad_cfg();
    obs_t o, e;
    int cfg [2][2] = '{'{7, 7}, '{9, 3}};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.lo = 4'(cfg[k][0]); bus.hi = 4'(cfg[k][1]); bus.continuous = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      e = idle_exp; e.err = 1'b1;
      @(negedge clk); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL bad_cfg%0d_err: got %h expected %h", k, o, e); end
      @(negedge clk); o = observe(); checks++;
      if (o !== idle_exp) begin errors++; $display("FAIL bad_cfg%0d_after: got %h expected %h", k, o, idle_exp); end
    end
  endtask

  task automatic test_start_stop();
    obs_t o;
    @(posedge clk); #1;
    bus.lo = 4'd2; bus.hi = 4'd5; bus.continuous = 1'b0; bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== idle_exp) begin errors++; $display("FAIL start_stop[%0d]: got %h expected %h", i, o, idle_exp); end
    end
  endtask

  // Continuous bounce over the full range, aborted as the second sweep lands on lo.
  task automatic test_continuous();
    obs_t o, e;
    int k;
    gen_sweep(0, 15, 1'b1, 2);
    k = exp_q.size() - 1;
    start_op(0, 15, 1'b1);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL cont[%0d]: got %h expected %h", i, o, exp_q[i]); end
      scramble(1'b1);
    end
    @(posedge clk); #1; bus.stop = 1'b1;
    e = exp_q[k]; e.up = 1'b0; e.down = 1'b0;
    @(negedge clk); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL cont_stop: got %h expected %h", o, e); end
    @(posedge clk); #1; bus.stop = 1'b0; bus.start = 1'b0;
    e = mk(exp_q[k].cnt, 0, 0, 1, 0, 0, 0, 0, exp_q[k].sw);
    @(negedge clk); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL cont_idle: got %h expected %h", o, e); end
    idle_exp = e;
  endtask

  task automatic test_stop_mid();
    obs_t o, e;
    int k = 7; // cycle in UP where the counter reads 6 (CLR + 0..1 + 2..6)
    gen_sweep(1, 9, 1'b1, 1);
    start_op(1, 9, 1'b1);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL stop_mid[%0d]: got %h expected %h", i, o, exp_q[i]); end
      scramble(1'b1);
    end
    @(posedge clk); #1; bus.stop = 1'b1;
    e = mk(6, 0, 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL stop_mid_cycle: got %h expected %h", o, e); end
    @(posedge clk); #1; bus.stop = 1'b0; bus.start = 1'b0;
    e = mk(6, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL stop_mid_hold[%0d]: got %h expected %h", i, o, e); end
    end
    idle_exp = e;
  endtask

  task automatic test_random();
    obs_t o, e;
    int lo, hi, nsw, k;
    bit cont;
    for (int it = 0; it < 6; it++) begin
      lo   = $urandom_range(0, 14);
      hi   = $urandom_range(lo + 1, 15);
      cont = 1'($urandom_range(0, 1));
      nsw  = $urandom_range(1, 2);
      gen_sweep(lo, hi, cont, nsw);
      k = cont ? $urandom_range(1, exp_q.size() - 1) : exp_q.size();
      start_op(lo, hi, cont);
      for (int i = 0; i < k; i++) begin
        @(negedge clk); o = observe(); checks++;
        if (o !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d[%0d] lo=%0d hi=%0d: got %h expected %h", it, i, lo, hi, o, exp_q[i]);
        end
        scramble(exp_q[i].busy);
      end
      if (cont) begin
        @(posedge clk); #1; bus.stop = 1'b1;
        e = exp_q[k]; e.up = 1'b0; e.down = 1'b0;
        @(negedge clk); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL rand%0d_stop: got %h expected %h", it, o, e); end
        @(posedge clk); #1; bus.stop = 1'b0; bus.start = 1'b0;
        e = mk(exp_q[k].cnt, 0, 0, 1, 0, 0, 0, 0, exp_q[k].sw);
        @(negedge clk); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL rand%0d_idle: got %h expected %h", it, o, e); end
        idle_exp = e;
      end else begin
        idle_exp = exp_q[exp_q.size()-1];
      end
    end
  endtask

  // Narrow sweep counter on the second instance must wrap 3 -> 0.
  task automatic test_sweep_w2();
    gen_sweep(0, 1, 1'b1, 6);
    @(posedge clk); #1;
    bus2.lo = 4'd0; bus2.hi = 4'd1; bus2.continuous = 1'b1; bus2.start = 1'b1;
    @(posedge clk); #1; bus2.start = 1'b0;
    foreach (exp_q[i]) begin
      @(negedge clk); checks++;
      if ({cnt2, bus2.sweeps} !== {exp_q[i].cnt, exp_q[i].sw[1:0]}) begin
        errors++; $display("FAIL sweep_w2[%0d]: got cnt=%0d sw=%0d expected cnt=%0d sw=%0d",
                           i, cnt2, bus2.sweeps, exp_q[i].cnt, exp_q[i].sw[1:0]);
      end
    end
    @(posedge clk); #1; bus2.stop = 1'b1;
    @(posedge clk); #1; bus2.stop = 1'b0;
    @(negedge clk); checks++;
    if (bus2.busy !== 1'b0) begin errors++; $display("FAIL sweep_w2_stop: got busy=%b expected 0", bus2.busy); end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    start_op(3, 12, 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1; clear_b = 1'b0;
    #1;
    o = observe(); e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid: got %h expected %h", o, e); end
    @(negedge clk); clear_b = 1'b1;
    @(negedge clk); o = observe(); e = mk(0, 0, 0, 1, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid_release: got %h expected %h", o, e); end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0; bus.lo = 4'd0; bus.hi = 4'd0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.continuous = 1'b0; bus2.lo = 4'd0; bus2.hi = 4'd0;
    test_reset();
    test_single_sweep();
    test_bad_cfg();
    test_start_stop();
    test_continuous();
    test_stop_mid();
    test_random();
    test_sweep_w2();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
